// File: rtl/ram_io_pkg.sv
// Shared definitions for the RAM input reader: width defaults and FSM state encoding.
package ram_io_pkg;

  localparam int unsigned DefaultDataWidth = 8;
  localparam int unsigned DefaultAddrWidth = 10;

  // Reads in flight plus words buffered never exceed the FIFO depth.
  localparam int unsigned MaxOutstanding = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that absorbs RAM read data while the consumer stalls.
// Push and pop in the same cycle are legal at any occupancy.
module skid_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // Qualify requests; when full, a push is only taken together with a pop.
  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; a push at full writes the slot being popped this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Head of queue presented directly.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    head_valid = (count_q != 2'd0);
    count      = count_q;
  end

endmodule

// File: rtl/ram_input_reader.sv
// Burst reader: streams len words starting at base_addr out of a synchronous-read RAM,
// with a ready/valid output and at most two words outstanding.
module ram_input_reader
  import ram_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CntW-1:0]       len_q, len_d;
  logic [CntW-1:0]       issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  in_flight_q;
  logic                  in_flight_last_q;
  logic                  hold_q, hold_d;

  logic                  issue;
  logic                  issue_last;
  logic                  pop;
  logic [1:0]            occupancy;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  fifo_valid;

  // Words still owed to the FIFO after this cycle's pop; gates new reads.
  always_comb begin
    pop       = fifo_valid && dout_ready;
    occupancy = 2'(in_flight_q) + fifo_count - 2'(pop);
  end

  // Next-state, read issue and address generation.
  // The first read is issued in the same cycle start is seen so data lands two cycles later.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    hold_d     = hold_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    ram_addr   = addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d   = base_addr;
          len_d    = len;
          issued_d = '0;
          if (len == '0) begin
            // Zero-length burst waits one cycle so done lands where a read pipeline would.
            state_d = StDone;
            hold_d  = 1'b1;
          end else begin
            issue      = 1'b1;
            ram_addr   = base_addr;
            issued_d   = CntW'(1);
            issue_last = (len == CntW'(1));
            state_d    = issue_last ? StDrain : StRun;
          end
        end
      end
      StRun: begin
        if (occupancy < 2'(MaxOutstanding)) begin
          issue      = 1'b1;
          ram_addr   = base_q + issued_q[ADDR_WIDTH-1:0];
          issued_d   = issued_q + CntW'(1);
          issue_last = (issued_d == len_q);
          if (issue_last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Nothing is issued here, so zero occupancy means the last word leaves this cycle.
        if (occupancy == 2'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state; reset abandons any burst, including data still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      base_q           <= '0;
      len_q            <= '0;
      issued_q         <= '0;
      addr_q           <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      hold_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      len_q            <= len_d;
      issued_q         <= issued_d;
      addr_q           <= ram_addr;
      in_flight_q      <= issue;
      in_flight_last_q <= issue_last;
      hold_q           <= hold_d;
    end
  end

  // RAM data is captured one cycle after issue, tagged with its last-word flag.
  skid_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight_q),
    .push_data ({in_flight_last_q, ram_q}),
    .pop       (pop),
    .head      (fifo_head),
    .head_valid(fifo_valid),
    .count     (fifo_count)
  );

  // Output stream and status.
  always_comb begin
    dout       = fifo_head[DATA_WIDTH-1:0];
    dout_valid = fifo_valid;
    dout_last  = fifo_valid && fifo_head[DATA_WIDTH];
    busy       = (state_q != StIdle);
    done       = (state_q == StDone) && !hold_q;
  end

endmodule

// File: tb/tb_ram_input_reader.sv
// Self-checking bench for ram_input_reader: table vectors, hand sequences, random bursts.
module tb_ram_input_reader;

  localparam int DW     = 8;
  localparam int AW     = 10;
  localparam int MaxCyc = 3000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] mem [1 << AW];

  ram_input_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_q     (ram_q),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last (dout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model.
  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one burst and scores the output stream against the ideal word list
  // mem[base + i], i < n. Cycle 0 is the cycle start is high.
  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] n, input int rdy_pct,
                           input int noise_cyc, input int abort_after,
                           output int first_cyc, output int done_cyc, output int last_acc);
    int            got;
    bit            aborted;
    bit            prev_stall;
    bit            r;
    logic [DW-1:0] held_d;
    logic          held_l;
    logic [AW-1:0] a;
    got = 0; aborted = 0; prev_stall = 0; held_d = '0; held_l = 1'b0;
    first_cyc = -1; done_cyc = -1; last_acc = -1;
    for (int c = 0; c < MaxCyc && done_cyc < 0 && !aborted; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("stall_valid", dout_valid, 1'b1);
        check("stall_data", dout, held_d);
        check("stall_last", dout_last, held_l);
      end
      if (done) done_cyc = c;
      if (c == 1) check("busy_after_start", busy, 1'b1);
      r          = ($urandom_range(99) < rdy_pct);
      dout_ready = r;
      start      = (c == 0) || (c == noise_cyc);
      base_addr  = (c == 0) ? b : ~b;
      len        = (c == 0) ? n : 11'd3;
      if (dout_valid && first_cyc < 0) first_cyc = c;
      if (dout_valid && r) begin
        if (got < int'(n)) begin
          a = b + AW'(got);
          check("data", dout, mem[a]);
          check("last_flag", dout_last, (got == int'(n) - 1));
        end else begin
          check("overrun_count", got, int'(n) - 1);
        end
        got++;
        last_acc = c;
        if (abort_after > 0 && got == abort_after) aborted = 1;
      end
      prev_stall = dout_valid && !r;
      held_d     = dout;
      held_l     = dout_last;
    end
    start = 1'b0;
    if (!aborted) check("word_count", got, n);
  endtask

  task automatic do_burst(input logic [AW-1:0] b, input logic [AW:0] n, input int rdy_pct,
                          input int noise_cyc, input int exp_done_tbl);
    int fc, dc, la;
    run_burst(b, n, rdy_pct, noise_cyc, -1, fc, dc, la);
    check("first_valid", fc, (n == 0) ? -1 : 2);
    check("done_cycle", dc, (n == 0) ? 2 : la + 1);
    if (exp_done_tbl >= 0) check("done_table", dc, exp_done_tbl);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_cleared", busy, 1'b0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            rdy;
    int            noise;
    int            exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int fc, dc, la;
    for (int i = 0; i < (1 << AW); i++) begin
      logic [AW-1:0] ai;
      ai     = AW'(i);
      mem[i] = (ai[7:0] + 8'h10) ^ {ai[9:8], 6'b0};
    end
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; dout_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_last", dout_last, 1'b0);
    check("rst_addr", ram_addr, '0);
    check("rst_dout", dout, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // base, len, ready %, stray start cycle, expected done cycle (-1: model only)
    vecs[0] = '{10'h000, 11'd4,    100, -1, 6};
    vecs[1] = '{10'h3FE, 11'd4,    100, -1, 6};
    vecs[2] = '{10'h155, 11'd0,    100, -1, 2};
    vecs[3] = '{10'h020, 11'd1,    100, -1, 3};
    vecs[4] = '{10'h100, 11'd8,    50,  -1, -1};
    vecs[5] = '{10'h3FF, 11'd2,    100, -1, 4};
    vecs[6] = '{10'h200, 11'd1024, 100, -1, 1026};
    for (int i = 0; i < 7; i++) begin
      do_burst(vecs[i].base, vecs[i].len, vecs[i].rdy, vecs[i].noise, vecs[i].exp_done);
    end

    // Stray start while busy must not disturb the running burst.
    do_burst(10'h0A0, 11'd6, 100, 3, 8);
    do_burst(10'h3F0, 11'd8, 40, 2, -1);

    // Reset after three of ten words: outputs clear at once and no done follows.
    run_burst(10'h050, 11'd10, 100, -1, 3, fc, dc, la);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_valid", dout_valid, 1'b0);
    check("abort_last", dout_last, 1'b0);
    check("abort_addr", ram_addr, '0);
    check("abort_dout", dout, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_done_after_abort", done, 1'b0);
      check("no_valid_after_abort", dout_valid, 1'b0);
    end
    do_burst(10'h3FF, 11'd2, 100, -1, 4);

    // Random bursts scored against the ideal stream.
    for (int k = 0; k < 20; k++) begin
      logic [AW-1:0] rb;
      logic [AW:0]   rn;
      rb = AW'($urandom_range(1023));
      rn = ($urandom_range(7) == 0) ? 11'd0 : 11'($urandom_range(24, 1));
      do_burst(rb, rn, $urandom_range(100, 20), $urandom_range(6, 1), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
